// File: rtl/ahbmst.sv
// AHB-Lite burst master: arbitrates, issues NONSEQ/SEQ beats, splits at P_BOUND, retries and recovers.
// Optional macro AHBMST_BUSY_EN: fixed-length bursts with BUSY on write underflow.
module ahbmst #(
  parameter int P_DW    = 32,
  parameter int P_BOUND = 1024
) (
  input  logic            I_AHBMST_HCLK,
  input  logic            I_AHBMST_HRESET_N,
  input  logic            I_AHBMST_START,
  input  logic [31:0]     I_AHBMST_ADDR,
  input  logic [4:0]      I_AHBMST_COUNT,
  input  logic [2:0]      I_AHBMST_SIZE,
  input  logic            I_AHBMST_WRITE,
  input  logic [P_DW-1:0] I_AHBMST_WDATA,
  input  logic            I_AHBMST_WVALID,
  output logic            O_AHBMST_WREADY,
  output logic [P_DW-1:0] O_AHBMST_RDATA,
  output logic            O_AHBMST_RVALID,
  output logic            O_AHBMST_BUSY,
  output logic            O_AHBMST_DONE,
  output logic            O_AHBMST_ERR,
  output logic [31:0]     O_AHBMST_HADDR,
  output logic [1:0]      O_AHBMST_HTRANS,
  output logic [2:0]      O_AHBMST_HSIZE,
  output logic [2:0]      O_AHBMST_HBURST,
  output logic            O_AHBMST_HWRITE,
  output logic [P_DW-1:0] O_AHBMST_HWDATA,
  output logic            O_AHBMST_HBUSREQ,
  input  logic            I_AHBMST_HGRANT,
  input  logic            I_AHBMST_HREADY,
  input  logic [1:0]      I_AHBMST_HRESP,
  input  logic [P_DW-1:0] I_AHBMST_HRDATA
);

`ifdef AHBMST_BUSY_EN
  localparam logic BUSY_EN = 1'b1;
`else
  localparam logic BUSY_EN = 1'b0;
`endif

  localparam int          NB         = P_DW / 8;
  localparam logic [2:0]  MAX_SIZE   = 3'($clog2(NB));
  localparam logic [31:0] BOUND_MASK = 32'(P_BOUND - 1);

  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_ERROR = 2'b01;
  localparam logic [2:0] HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_INCR4 = 3'd3,
                         HB_INCR8 = 3'd5, HB_INCR16 = 3'd7;

  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_NSEQ = 3'd2, S_SEQ = 3'd3,
                         S_BUSY = 3'd4, S_WAITD = 3'd5, S_ERR = 3'd6;

  logic [2:0]      state;
  logic [31:0]     addr;
  logic [2:0]      size;
  logic            write;
  logic [2:0]      burst;
  logic            incr;
  logic            replay;
  logic [4:0]      rem;
  logic            dph;
  logic            dph_write;
  logic [31:0]     dph_addr;
  logic [P_DW-1:0] hwdata;
  logic [P_DW-1:0] rdata;
  logic            rvalid;
  logic            done;
  logic            err;

  logic [4:0]  cnt_c;
  logic [2:0]  size_c;
  logic [31:0] mask_c, addr_c, last_c;
  logic        split_c;
  logic [2:0]  burst_c;

  logic [31:0] inc, next_addr;
  logic        at_bound, active, resp_bad, underflow, accept;
  logic [1:0]  trans;

  // Narrow beats put the same bytes on every lane group of HWDATA.
  function automatic logic [P_DW-1:0] rep_wdata(input logic [P_DW-1:0] d, input logic [2:0] sz);
    logic [P_DW-1:0] r;
    int lane_mask;
    lane_mask = (1 << sz) - 1;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = d[8*(i & lane_mask) +: 8];
    return r;
  endfunction

  always_comb begin
    cnt_c = I_AHBMST_COUNT;
    if (I_AHBMST_COUNT == 5'd0) cnt_c = 5'd1;
    else if (I_AHBMST_COUNT > 5'd16) cnt_c = 5'd16;
    size_c  = (I_AHBMST_SIZE > MAX_SIZE) ? MAX_SIZE : I_AHBMST_SIZE;
    mask_c  = (32'd1 << size_c) - 32'd1;
    addr_c  = (I_AHBMST_ADDR + mask_c) & ~mask_c;
    last_c  = addr_c + ((32'(cnt_c) - 32'd1) << size_c);
    split_c = (addr_c & ~BOUND_MASK) != (last_c & ~BOUND_MASK);
    burst_c = HB_INCR;
    if (BUSY_EN && !split_c) begin
      case (cnt_c)
        5'd1:    burst_c = HB_SINGLE;
        5'd4:    burst_c = HB_INCR4;
        5'd8:    burst_c = HB_INCR8;
        5'd16:   burst_c = HB_INCR16;
        default: burst_c = HB_INCR;
      endcase
    end
  end

  // A lost grant, a bad response or missing write data all suppress the address phase.
  always_comb begin
    inc       = 32'd1 << size;
    next_addr = addr + inc;
    at_bound  = (next_addr & BOUND_MASK) == 32'd0;
    active    = (state == S_NSEQ) || (state == S_SEQ) || (state == S_BUSY);
    resp_bad  = dph && (I_AHBMST_HRESP != RESP_OKAY);
    underflow = write && !replay && !I_AHBMST_WVALID;
    trans     = TR_IDLE;
    accept    = 1'b0;
    if (active && !resp_bad && I_AHBMST_HGRANT) begin
      if (underflow) begin
        if (BUSY_EN && state != S_NSEQ) trans = TR_BUSY;
      end else begin
        trans  = (state == S_NSEQ) ? TR_NSEQ : TR_SEQ;
        accept = I_AHBMST_HREADY;
      end
    end
  end

  always_ff @(posedge I_AHBMST_HCLK or negedge I_AHBMST_HRESET_N) begin
    if (!I_AHBMST_HRESET_N) begin
      state     <= S_IDLE;
      addr      <= '0;
      size      <= '0;
      write     <= 1'b0;
      burst     <= HB_SINGLE;
      incr      <= 1'b0;
      replay    <= 1'b0;
      rem       <= '0;
      dph       <= 1'b0;
      dph_write <= 1'b0;
      dph_addr  <= '0;
      hwdata    <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done   <= 1'b0;
      rvalid <= dph && !dph_write && I_AHBMST_HREADY && (I_AHBMST_HRESP == RESP_OKAY);
      if (dph && !dph_write && I_AHBMST_HREADY && (I_AHBMST_HRESP == RESP_OKAY))
        rdata <= I_AHBMST_HRDATA;
      if (I_AHBMST_HREADY) dph <= accept;
      if (accept) begin
        dph_addr  <= addr;
        dph_write <= write;
      end

      // Failed data phase: ERROR aborts, RETRY/SPLIT re-arbitrates and replays the beat.
      if ((active || state == S_WAITD) && resp_bad) begin
        dph <= 1'b0;
        if (I_AHBMST_HRESP == RESP_ERROR) begin
          state <= S_ERR;
        end else begin
          state  <= S_REQ;
          addr   <= dph_addr;
          rem    <= rem + 5'd1;
          incr   <= 1'b1;
          replay <= dph_write;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (I_AHBMST_START) begin
              state  <= S_REQ;
              addr   <= addr_c;
              size   <= size_c;
              write  <= I_AHBMST_WRITE;
              burst  <= burst_c;
              incr   <= 1'b0;
              replay <= 1'b0;
              rem    <= cnt_c;
              err    <= 1'b0;
            end
          end
          S_REQ: begin
            if (I_AHBMST_HGRANT && I_AHBMST_HREADY) state <= S_NSEQ;
          end
          S_NSEQ, S_SEQ, S_BUSY: begin
            if (!I_AHBMST_HGRANT) begin
              if (I_AHBMST_HREADY) begin
                state <= S_REQ;
                incr  <= 1'b1;
              end
            end else if (underflow) begin
              if (I_AHBMST_HREADY && state != S_NSEQ) state <= BUSY_EN ? S_BUSY : S_NSEQ;
            end else if (accept) begin
              addr   <= next_addr;
              rem    <= rem - 5'd1;
              replay <= 1'b0;
              if (write && !replay) hwdata <= rep_wdata(I_AHBMST_WDATA, size);
              if (rem == 5'd1) begin
                state <= S_WAITD;
              end else if (at_bound) begin
                state <= S_NSEQ;
                incr  <= 1'b1;
              end else begin
                state <= S_SEQ;
              end
            end
          end
          S_WAITD: begin
            if (I_AHBMST_HREADY) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          S_ERR: begin
            if (I_AHBMST_HREADY) begin
              state <= S_IDLE;
              err   <= 1'b1;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign O_AHBMST_WREADY  = accept && write && !replay;
  assign O_AHBMST_RDATA   = rdata;
  assign O_AHBMST_RVALID  = rvalid;
  assign O_AHBMST_BUSY    = state != S_IDLE;
  assign O_AHBMST_DONE    = done;
  assign O_AHBMST_ERR     = err;
  assign O_AHBMST_HADDR   = addr;
  assign O_AHBMST_HTRANS  = trans;
  assign O_AHBMST_HSIZE   = size;
  assign O_AHBMST_HBURST  = incr ? HB_INCR : burst;
  assign O_AHBMST_HWRITE  = write;
  assign O_AHBMST_HWDATA  = hwdata;
  assign O_AHBMST_HBUSREQ = active || (state == S_REQ);

endmodule

// File: tb/tb_ahbmst.sv
// Directed bench for ahbmst: hand-computed beat sequences with a trivial zero-wait slave.
module tb_ahbmst;

`ifdef AHBMST_BUSY_EN
  localparam logic BE = 1'b1;
`else
  localparam logic BE = 1'b0;
`endif

  localparam logic [31:0] RMASK = 32'hA5A5_0000;
  localparam logic [1:0]  T_I = 2'b00, T_B = 2'b01, T_N = 2'b10, T_S = 2'b11;
  localparam logic [2:0]  B_SINGLE = BE ? 3'd0 : 3'd1;
  localparam logic [2:0]  B_INCR   = 3'd1;
  localparam logic [2:0]  B_INCR4  = BE ? 3'd3 : 3'd1;
  localparam logic [2:0]  B_INCR8  = BE ? 3'd5 : 3'd1;
  localparam logic [1:0]  TX = BE ? T_B : T_I;
  localparam logic [1:0]  TY = BE ? T_S : T_N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [4:0]  count = '0;
  logic [2:0]  size = '0;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b1;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid, busy, done, err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hbusreq;
  logic        hgrant = 1'b1;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;
  logic [31:0] hrdata;
  logic [31:0] dp_addr = '0;

  int nchk = 0;
  int nerr = 0;
  int rcnt;

  logic [31:0] t3_addr  [10] = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h30C,
                                 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C};
  logic [1:0]  t3_trans [10] = '{T_N, T_S, T_S, TX, TX, TY, T_S, T_S, T_S, T_S};
  logic        t3_wv    [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] t4_addr  [10] = '{32'h500, 32'h504, 32'h508, 32'h508, 32'h508,
                                 32'h50C, 32'h510, 32'h514, 32'h518, 32'h51C};
  logic [1:0]  t4_trans [10] = '{T_N, T_S, T_I, T_I, T_N, T_S, T_S, T_S, T_S, T_S};
  logic        t4_gnt   [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  // Zero-wait slave: read data is derived from the address of the current data phase.
  always @(posedge clk) if (hready && htrans[1]) dp_addr <= haddr;
  assign hrdata = dp_addr ^ RMASK;

  ahbmst dut (
    .I_AHBMST_HCLK(clk), .I_AHBMST_HRESET_N(rst_n), .I_AHBMST_START(start),
    .I_AHBMST_ADDR(addr), .I_AHBMST_COUNT(count), .I_AHBMST_SIZE(size),
    .I_AHBMST_WRITE(write), .I_AHBMST_WDATA(wdata), .I_AHBMST_WVALID(wvalid),
    .O_AHBMST_WREADY(wready), .O_AHBMST_RDATA(rdata), .O_AHBMST_RVALID(rvalid),
    .O_AHBMST_BUSY(busy), .O_AHBMST_DONE(done), .O_AHBMST_ERR(err),
    .O_AHBMST_HADDR(haddr), .O_AHBMST_HTRANS(htrans), .O_AHBMST_HSIZE(hsize),
    .O_AHBMST_HBURST(hburst), .O_AHBMST_HWRITE(hwrite), .O_AHBMST_HWDATA(hwdata),
    .O_AHBMST_HBUSREQ(hbusreq), .I_AHBMST_HGRANT(hgrant), .I_AHBMST_HREADY(hready),
    .I_AHBMST_HRESP(hresp), .I_AHBMST_HRDATA(hrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a command, return 1ns after the negedge of the REQ cycle.
  task automatic cmd(input logic [31:0] a, input logic [4:0] n, input logic [2:0] sz, input logic w);
    @(negedge clk);
    start = 1'b1; addr = a; count = n; size = sz; write = w;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    @(negedge clk); #1;
    chk("rst_htrans", 32'(htrans), 32'(T_I));
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hburst", 32'(hburst), 32'h0);
    chk("rst_hbusreq", 32'(hbusreq), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // write INCR4 at 0x100
    wvalid = 1'b1;
    cmd(32'h100, 5'd4, 3'd2, 1'b1);
    chk("t1_busreq", 32'(hbusreq), 32'h1);
    chk("t1_req_trans", 32'(htrans), 32'(T_I));
    chk("t1_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wdata = 32'hD000_0000 + 32'(i); #1;
      chk("t1_trans", 32'(htrans), (i == 0) ? 32'(T_N) : 32'(T_S));
      chk("t1_addr", haddr, 32'h100 + 32'(4 * i));
      chk("t1_burst", 32'(hburst), 32'(B_INCR4));
      chk("t1_wready", 32'(wready), 32'h1);
      chk("t1_hwrite", 32'(hwrite), 32'h1);
      if (i > 0) chk("t1_hwdata", hwdata, 32'hD000_0000 + 32'(i - 1));
    end
    @(negedge clk); #1;
    chk("t1_waitd_trans", 32'(htrans), 32'(T_I));
    chk("t1_waitd_busreq", 32'(hbusreq), 32'h0);
    chk("t1_waitd_hwdata", hwdata, 32'hD000_0003);
    chk("t1_waitd_done", 32'(done), 32'h0);
    @(negedge clk); #1;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // narrow write: unaligned address rounded up, halfword replicated
    wdata = 32'h1234_ABCD;
    cmd(32'h201, 5'd1, 3'd1, 1'b1);
    @(negedge clk); #1;
    chk("t1b_trans", 32'(htrans), 32'(T_N));
    chk("t1b_addr", haddr, 32'h202);
    chk("t1b_size", 32'(hsize), 32'h1);
    chk("t1b_burst", 32'(hburst), 32'(B_SINGLE));
    @(negedge clk); #1;
    chk("t1b_hwdata", hwdata, 32'hABCD_ABCD);
    // back-to-back: START during the DONE cycle; oversize SIZE clamps to word
    @(negedge clk);
    start = 1'b1; addr = 32'h1; count = 5'd0; size = 3'd3; write = 1'b0;
    #1;
    chk("t1c_done", 32'(done), 32'h1);
    @(negedge clk); start = 1'b0; #1;
    chk("t1c_b2b_busreq", 32'(hbusreq), 32'h1);
    @(negedge clk); #1;
    chk("t1c_addr", haddr, 32'h4);
    chk("t1c_size", 32'(hsize), 32'h2);
    @(negedge clk); @(negedge clk); #1;
    chk("t1c_rdata", rdata, 32'h4 ^ RMASK);
    chk("t1c_done2", 32'(done), 32'h1);

    // read across the 1KB boundary
    cmd(32'h3F8, 5'd4, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t2_trans", 32'(htrans), (i == 0 || i == 2) ? 32'(T_N) : 32'(T_S));
      chk("t2_addr", haddr, 32'h3F8 + 32'(4 * i));
      chk("t2_burst", 32'(hburst), 32'(B_INCR));
      chk("t2_hwrite", 32'(hwrite), 32'h0);
      if (i >= 2) begin
        chk("t2_rvalid", 32'(rvalid), 32'h1);
        chk("t2_rdata", rdata, (32'h3F8 + 32'(4 * (i - 2))) ^ RMASK);
      end
    end
    @(negedge clk); #1;
    chk("t2_rdata_g", rdata, 32'h400 ^ RMASK);
    chk("t2_rvalid_g", 32'(rvalid), 32'h1);
    @(negedge clk); #1;
    chk("t2_rdata_h", rdata, 32'h404 ^ RMASK);
    chk("t2_done", 32'(done), 32'h1);

    // write underflow after beat 3
    cmd(32'h300, 5'd8, 3'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); wvalid = t3_wv[i]; wdata = 32'hC000_0000 + 32'(i); #1;
      chk("t3_trans", 32'(htrans), 32'(t3_trans[i]));
      chk("t3_addr", haddr, t3_addr[i]);
      chk("t3_wready", 32'(wready), 32'(t3_wv[i]));
      chk("t3_burst", 32'(hburst), 32'(B_INCR8));
    end
    wvalid = 1'b1;
    @(negedge clk); #1;
    chk("t3_waitd_hwdata", hwdata, 32'hC000_0009);
    @(negedge clk); #1;
    chk("t3_done", 32'(done), 32'h1);

    // grant loss after beat 2 of an 8-beat read
    cmd(32'h500, 5'd8, 3'd2, 1'b0);
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hgrant = t4_gnt[i]; #1;
      chk("t4_trans", 32'(htrans), 32'(t4_trans[i]));
      chk("t4_addr", haddr, t4_addr[i]);
      chk("t4_busreq", 32'(hbusreq), 32'h1);
      if (i == 0) chk("t4_burst_first", 32'(hburst), 32'(B_INCR8));
      if (i == 4) chk("t4_burst_resume", 32'(hburst), 32'(B_INCR));
      if (rvalid) rcnt++;
    end
    @(negedge clk); #1;
    if (rvalid) rcnt++;
    @(negedge clk); #1;
    if (rvalid) rcnt++;
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_rvalid_count", 32'(rcnt), 32'd8);
    chk("t4_last_rdata", rdata, 32'h51C ^ RMASK);

    // ERROR response on beat 2 of a 4-beat write
    cmd(32'h600, 5'd4, 3'd2, 1'b1);
    @(negedge clk); #1;
    chk("t5_trans0", 32'(htrans), 32'(T_N));
    @(negedge clk); #1;
    chk("t5_addr1", haddr, 32'h604);
    @(negedge clk); hready = 1'b0; hresp = 2'b01; #1;
    chk("t5_err1_trans", 32'(htrans), 32'(T_I));
    chk("t5_err1_wready", 32'(wready), 32'h0);
    @(negedge clk); hready = 1'b1; #1;
    chk("t5_err2_trans", 32'(htrans), 32'(T_I));
    chk("t5_err2_busreq", 32'(hbusreq), 32'h0);
    @(negedge clk); hresp = 2'b00; #1;
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_after_trans", 32'(htrans), 32'(T_I));

    // async reset mid-burst, then a normal single read
    cmd(32'h700, 5'd8, 3'd2, 1'b0);
    chk("t6_err_cleared", 32'(err), 32'h0);
    @(negedge clk); #1;
    chk("t6_trans0", 32'(htrans), 32'(T_N));
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("t6_rst_htrans", 32'(htrans), 32'(T_I));
    chk("t6_rst_haddr", haddr, 32'h0);
    chk("t6_rst_busreq", 32'(hbusreq), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_hburst", 32'(hburst), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    cmd(32'h40, 5'd1, 3'd2, 1'b0);
    chk("t6_busreq", 32'(hbusreq), 32'h1);
    @(negedge clk); #1;
    chk("t6_trans", 32'(htrans), 32'(T_N));
    chk("t6_addr", haddr, 32'h40);
    chk("t6_burst", 32'(hburst), 32'(B_SINGLE));
    @(negedge clk); @(negedge clk); #1;
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_rvalid", 32'(rvalid), 32'h1);
    chk("t6_rdata", rdata, 32'h40 ^ RMASK);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ahbmst.md
# ahbmst

Parametrised AHB-Lite bus master, the successor to the existing 32-bit rotate-engine AHB interface. It takes burst commands from the core, arbitrates for the bus, and issues NONSEQ/SEQ transfers. It adds a configurable data width, a write-data valid/ready handshake, BUSY insertion on write underflow, HRESP handling, and automatic re-issue after grant loss or a 1 KB boundary crossing. It sits between the core/FIFOs and the AHB arbiter/slave.

## Interface
- P_DW, 32, data width (32 or 64)
- P_BOUND, 1024, address boundary in bytes that a burst must not cross
- I_AHBMST_HCLK  in  1  bus clock
- I_AHBMST_HRESET_N  in  1  asynchronous active-low reset
- I_AHBMST_START  in  1  command pulse; sampled only in IDLE
- I_AHBMST_ADDR  in  32  start byte address
- I_AHBMST_COUNT  in  5  beats, 1..16 (0 treated as 1)
- I_AHBMST_SIZE  in  3  beat size; clamped to log2(P_DW/8)
- I_AHBMST_WRITE  in  1  1 = write command
- I_AHBMST_WDATA / I_AHBMST_WVALID  in  P_DW / 1  write data from output FIFO
- O_AHBMST_WREADY  out  1  write data consumed this cycle
- O_AHBMST_RDATA / O_AHBMST_RVALID  out  P_DW / 1  read data to input FIFO
- O_AHBMST_BUSY / O_AHBMST_DONE / O_AHBMST_ERR  out  1  command active / 1-cycle completion pulse / sticky error (cleared by START)
- O_AHBMST_HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HBUSREQ  out  32,2,3,3,1,P_DW,1  AHB master outputs
- I_AHBMST_HGRANT, HREADY, HRESP, HRDATA  in  1,1,2,P_DW  AHB inputs

## Operation
- States: IDLE, REQ, NSEQ, SEQ, BUSY, WAITD (last data phase), ERR.
- IDLE→REQ on START. The command is latched, HBUSREQ asserts and BUSY goes 1.
- REQ→NSEQ when HGRANT & HREADY.
- NSEQ/SEQ→SEQ on an accepted address phase when beats remain and no split is needed.
- →WAITD after the final address phase. WAITD→IDLE on HREADY, with a DONE pulse.
- Alignment: a misaligned ADDR is rounded up to the next SIZE-aligned address.
- Address increment per beat is 1<<SIZE, computed in 32 bits; 32-bit wrap is permitted.
- Boundary split: if the next address is a multiple of P_BOUND, the next beat is NONSEQ with HBURST=INCR.
- HBURST:
  - SINGLE/INCR4/INCR8/INCR16 when COUNT is 1/4/8/16 and no split is possible.
  - Otherwise INCR.
  - Re-issued segments always use INCR.
- Grant loss: HGRANT low at an accepted address phase → drive HTRANS IDLE and return to REQ with HBUSREQ held. The remaining beats resume as NONSEQ INCR.
- Write underflow (WVALID low when a write beat's address is due): drive HTRANS BUSY with HADDR held. Leave BUSY on WVALID.
- HRESP=ERROR:
  - On the first cycle, drive HTRANS IDLE and go to ERR.
  - On the second cycle, set ERR=1 and pulse DONE.
  - Go to IDLE; the remaining beats are dropped.
- HRESP=RETRY/SPLIT: re-issue the failed beat's address as NONSEQ INCR after re-arbitration (REQ).
- Write data lanes: narrow beats replicate WDATA[8<<SIZE-1:0] across HWDATA.
- Read data: RDATA/RVALID register HRDATA on each read data phase with HREADY & HRESP=OKAY.
- HBUSREQ deasserts the cycle after the final address phase is accepted.
- Reset mid-operation: all state aborts immediately and outputs take their reset values.

## Timing
- Reset values: all outputs 0; HTRANS=IDLE(00), HBURST=SINGLE, HSIZE=000.
- START→HBUSREQ: 1 cycle. HGRANT&HREADY sampled in REQ→NONSEQ on the next cycle.
- The address phase of beat n+1 coincides with the data phase of beat n. Outputs hold while HREADY=0.
- WREADY=1 exactly in cycles where a write NONSEQ/SEQ address phase is accepted. WDATA is captured into HWDATA at that edge.
- RVALID asserts 1 cycle after the read data phase completes.
- DONE asserts 1 cycle after the final data phase HREADY. START is accepted the same cycle DONE is high (back-to-back).
- Zero-wait 16-beat burst: 18 cycles from first NONSEQ to DONE.

## Configuration
- AHBMST_BUSY_EN defined: write underflow inserts BUSY as described.
- Without AHBMST_BUSY_EN:
  - HBURST is always INCR.
  - Underflow drives IDLE and returns to NSEQ, so the next beat is NONSEQ.
  - No BUSY encoding is ever emitted.

## Test plan
- Write, ADDR=0x100, COUNT=4, SIZE=2, WVALID=1, zero-wait → NONSEQ 0x100, SEQ 0x104/0x108/0x10C, HBURST=INCR4, DONE pulse.
- Read, ADDR=0x3F8, COUNT=4, SIZE=2 → beats 0x3F8, 0x3FC, then NONSEQ at 0x400, SEQ 0x404, all INCR; four RVALIDs.
- Write COUNT=8, WVALID low for 2 cycles after beat 3 → two BUSY cycles, HADDR held, no WREADY; burst completes (without the macro: IDLE, then NONSEQ).
- HGRANT dropped after beat 2 of a COUNT=8 read → HTRANS IDLE, REQ; re-granted → NONSEQ INCR at beat 3 address; 8 RVALIDs total.
- HRESP=ERROR on beat 2 of a COUNT=4 write → IDLE, ERR=1, DONE; no further address phases.
- Async reset asserted mid-burst → all outputs 0/IDLE immediately; next START runs normally.
